axi_sram_slave: RTL

AXI3 responder (slave) that terminates the core's 32-bit AXI master bus into an on-chip word-addressed SRAM array. It stands at the far end of the core's AXI port in simulation and FPGA bring-up, serving instruction and data fetches and stores. Read and write channels run independently, each with one outstanding burst. INCR, FIXED and WRAP bursts are supported.

---
 rtl/axi_sram_slave.sv | 234 +++++++++++++++++++++++
 1 files changed

// File: rtl/axi_sram_slave.sv
// axi_sram_slave: AXI3 slave that terminates a 32-bit bus into a word-addressed SRAM.
// Optional `AXI_SLV_DECERR_EN: bursts starting outside the window answer DECERR instead of aliasing.

module axi_sram_slave #(
  parameter int          MEM_AW    = 14,
  parameter logic [31:0] BASE_ADDR = 32'h1c00_0000
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  // state   | meaning
  // R_IDLE  | waiting for a read address
  // R_FETCH | array read of beat 0 in flight
  // R_DATA  | beat presented on the r channel
  // W_IDLE  | waiting for a write address
  // W_DATA  | accepting write beats
  // W_RESP  | write response pending

`ifdef AXI_SLV_DECERR_EN
  localparam bit DECERR_EN = 1'b1;
`else
  localparam bit DECERR_EN = 1'b0;
`endif

  typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

  r_state_t    r_state, r_state_nxt;
  w_state_t    w_state, w_state_nxt;
  logic        out_en;
  logic [31:0] mem [(1 << MEM_AW)];

  logic [3:0]  r_id, w_id;
  logic [31:0] r_addr, w_addr, r_addr_nxt, w_addr_nxt, rd_ptr, rd_off, wr_off;
  logic [7:0]  r_len, w_len, r_cnt, w_cnt;
  logic [2:0]  r_size, w_size;
  logic [1:0]  r_burst, w_burst;
  logic        r_err, w_err;
  logic        ar_fire, r_fire, aw_fire, w_fire;
  logic        unused_ok;

  function automatic logic [31:0] step_addr(input logic [31:0] addr, input logic [2:0] size,
                                            input logic [7:0] len, input logic [1:0] burst);
    logic [31:0] incr, mask;
    incr = 32'd1 << size;
    mask = (({24'd0, len} + 32'd1) << size) - 32'd1;
    case (burst)
      2'b00:   step_addr = addr;
      2'b10:   step_addr = (addr & ~mask) | ((addr + incr) & mask);
      default: step_addr = addr + incr;
    endcase
  endfunction

  function automatic logic in_map(input logic [31:0] addr);
    in_map = ((addr - BASE_ADDR) >> (MEM_AW + 2)) == 32'd0;
  endfunction

  assign r_addr_nxt = step_addr(r_addr, r_size, r_len, r_burst);
  assign w_addr_nxt = step_addr(w_addr, w_size, w_len, w_burst);
  // Beat 0 is fetched from the latched address, later beats from the stepped one.
  assign rd_ptr     = (r_state == R_FETCH) ? r_addr : r_addr_nxt;
  assign rd_off     = rd_ptr - BASE_ADDR;
  assign wr_off     = w_addr - BASE_ADDR;

  assign ar_fire = arvalid && arready;
  assign r_fire  = rvalid && rready;
  assign aw_fire = awvalid && awready;
  assign w_fire  = wvalid && wready;
  assign rid     = r_id;
  assign bid     = w_id;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state <= R_IDLE;
      w_state <= W_IDLE;
      out_en  <= 1'b0;
    end else begin
      r_state <= r_state_nxt;
      w_state <= w_state_nxt;
      out_en  <= 1'b1;
    end
  end

  always_comb begin
    r_state_nxt = r_state;
    arready     = 1'b0;
    rvalid      = 1'b0;
    rlast       = 1'b0;
    rresp       = 2'b00;
    case (r_state)
      R_IDLE: begin
        arready = out_en;
        if (arvalid && out_en) r_state_nxt = R_FETCH;
      end
      R_FETCH: r_state_nxt = R_DATA;
      R_DATA: begin
        rvalid = 1'b1;
        rlast  = (r_cnt == r_len);
        rresp  = r_err ? 2'b11 : 2'b00;
        if (rready && rlast) r_state_nxt = R_IDLE;
      end
      default: r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    w_state_nxt = w_state;
    awready     = 1'b0;
    wready      = 1'b0;
    bvalid      = 1'b0;
    bresp       = 2'b00;
    case (w_state)
      W_IDLE: begin
        awready = out_en;
        if (awvalid && out_en) w_state_nxt = W_DATA;
      end
      W_DATA: begin
        wready = 1'b1;
        if (wvalid && (w_cnt == w_len)) w_state_nxt = W_RESP;
      end
      W_RESP: begin
        bvalid = 1'b1;
        bresp  = w_err ? 2'b11 : 2'b00;
        if (bready) w_state_nxt = W_IDLE;
      end
      default: w_state_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_id    <= 4'd0;
      r_addr  <= 32'd0;
      r_len   <= 8'd0;
      r_size  <= 3'd0;
      r_burst <= 2'd0;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
      rdata   <= 32'd0;
    end else begin
      if (ar_fire) begin
        r_id    <= arid;
        r_addr  <= araddr;
        r_len   <= arlen;
        r_size  <= arsize;
        r_burst <= arburst;
        r_cnt   <= 8'd0;
        r_err   <= DECERR_EN && !in_map(araddr);
      end
      if (r_state == R_FETCH) rdata <= r_err ? 32'd0 : mem[rd_off[MEM_AW+1:2]];
      if (r_fire && !rlast) begin
        r_addr <= r_addr_nxt;
        r_cnt  <= r_cnt + 8'd1;
        rdata  <= r_err ? 32'd0 : mem[rd_off[MEM_AW+1:2]];
      end
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      w_id    <= 4'd0;
      w_addr  <= 32'd0;
      w_len   <= 8'd0;
      w_size  <= 3'd0;
      w_burst <= 2'd0;
      w_cnt   <= 8'd0;
      w_err   <= 1'b0;
    end else begin
      if (aw_fire) begin
        w_id    <= awid;
        w_addr  <= awaddr;
        w_len   <= awlen;
        w_size  <= awsize;
        w_burst <= awburst;
        w_cnt   <= 8'd0;
        w_err   <= DECERR_EN && !in_map(awaddr);
      end
      if (w_fire) begin
        w_addr <= w_addr_nxt;
        w_cnt  <= w_cnt + 8'd1;
      end
    end
  end

  // Array has no reset so its contents survive aresetn.
  always_ff @(posedge aclk) begin
    if (w_fire && !w_err) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) mem[wr_off[MEM_AW+1:2]][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

  assign unused_ok = ^{arlock, arcache, arprot, awlock, awcache, awprot, wid, wlast,
                       rd_off[31:MEM_AW+2], rd_off[1:0], wr_off[31:MEM_AW+2], wr_off[1:0]};

endmodule
